apb_master_ctrl: RTL and testbench

//  APB master sequencer. Two requesters share one APB bus. A round-robin grant feeds an IDLE/SETUP/ACCESS FSM.

---
 rtl/apb_master_ctrl_pkg.sv | 17 +
 rtl/apb_rr_arbiter.sv | 52 +++++
 rtl/apb_master_ctrl.sv | 146 ++++++++++++++
 tb/tb_apb_master_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_ctrl_pkg.sv
// Shared constants for the APB master sequencer: FSM encodings, requester ids
// and the address-decode bit position.
package apb_master_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

  // The slave decode uses the address MSB: 0 -> slave 1, 1 -> slave 2.
  function automatic int decode_bit(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// requester that was not granted last. last_grant resets to req1 so req0 wins first.
module apb_rr_arbiter
  import apb_master_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_grant;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    gnt    = 2'b00;
    gnt_id = REQ0_ID;
    if (en) begin
      case (req)
        2'b01: begin
          gnt    = 2'b01;
          gnt_id = REQ0_ID;
        end
        2'b10: begin
          gnt    = 2'b10;
          gnt_id = REQ1_ID;
        end
        2'b11: begin
          if (last_grant == REQ0_ID) begin
            gnt    = 2'b10;
            gnt_id = REQ1_ID;
          end else begin
            gnt    = 2'b01;
            gnt_id = REQ0_ID;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ1_ID;
    end else if (|gnt) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: round-robin between two requesters, IDLE/SETUP/ACCESS FSM,
// MSB address decode to PSEL1/PSEL2. Optional ACCESS timeout via APB_TIMEOUT_EN.
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              PREADY1,
  input  logic              PREADY2,
  input  logic [DATA_W-1:0] prdata1,
  input  logic [DATA_W-1:0] prdata2
);

  localparam int DEC_BIT = decode_bit(ADDR_W);

  logic [1:0]        state;
  logic              cur_id;
  logic [1:0]        gnt;
  logic              gnt_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              pready_sel;
  logic [DATA_W-1:0] prdata_sel;

  apb_rr_arbiter u_arb (
    .clk    (PCLK),
    .rst    (PRESET),
    .req    (req_valid),
    .en     (state == ST_IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // The accept pulse is combinational, so it is masked while reset holds outputs at 0.
  assign req_ready  = gnt & {2{~PRESET}};
  assign sel_addr   = (gnt_id == REQ1_ID) ? req_addr1  : req_addr0;
  assign sel_wdata  = (gnt_id == REQ1_ID) ? req_wdata1 : req_wdata0;
  assign sel_write  = req_write[gnt_id];
  assign pready_sel = PSEL2 ? PREADY2 : PREADY1;
  assign prdata_sel = PSEL2 ? prdata2 : prdata1;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign rsp_err        = 1'b0;
`endif

  // NOTE: all state here uses <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      cur_id    <= REQ0_ID;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            cur_id <= gnt_id;
            PWRITE <= sel_write;
            paddr  <= sel_addr;
            pwdata <= sel_wdata;
            PSEL1  <= ~sel_addr[DEC_BIT];
            PSEL2  <= sel_addr[DEC_BIT];
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_ACCESS: begin
          if (pready_sel) begin
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_rdata <= PWRITE ? '0 : prdata_sel;
            state     <= ST_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // The stalled slave is abandoned; the requester sees an error response.
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_id    <= cur_id;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: per-cycle vector table for single transfers and
// decode, plus hand sequences for round-robin, async reset and the ACCESS stall/timeout.
module tb_apb_master_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [1:0] req_valid, req_write, req_ready;
  logic [7:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic       rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] paddr, pwdata;
  logic       PREADY1, PREADY2;
  logic [7:0] prdata1, prdata2;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .paddr(paddr), .pwdata(pwdata),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .prdata1(prdata1), .prdata2(prdata2)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] rv, rw;
    logic [7:0] a0, a1, d0, d1;
    logic       r1, r2;
    logic [7:0] pd1, pd2;
    logic [1:0] e_rdy;
    logic       e_s1, e_s2, e_en, e_wr;
    logic [7:0] e_addr, e_wd;
    logic       e_rv, e_rid;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input vec_t v);
    req_valid = v.rv;  req_write  = v.rw;
    req_addr0 = v.a0;  req_addr1  = v.a1;
    req_wdata0 = v.d0; req_wdata1 = v.d1;
    PREADY1 = v.r1;    PREADY2 = v.r2;
    prdata1 = v.pd1;   prdata2 = v.pd2;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    check($sformatf("v%0d.req_ready", i), req_ready, v.e_rdy);
    check($sformatf("v%0d.psel1", i),     PSEL1,     v.e_s1);
    check($sformatf("v%0d.psel2", i),     PSEL2,     v.e_s2);
    check($sformatf("v%0d.penable", i),   PENABLE,   v.e_en);
    check($sformatf("v%0d.pwrite", i),    PWRITE,    v.e_wr);
    check($sformatf("v%0d.paddr", i),     paddr,     v.e_addr);
    check($sformatf("v%0d.pwdata", i),    pwdata,    v.e_wd);
    check($sformatf("v%0d.rsp_valid", i), rsp_valid, v.e_rv);
    check($sformatf("v%0d.rsp_id", i),    rsp_id,    v.e_rid);
    check($sformatf("v%0d.rsp_rdata", i), rsp_rdata, v.e_rd);
    check($sformatf("v%0d.rsp_err", i),   rsp_err,   1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"}, req_ready, 2'b00);
    check({tag, ".psel1"},     PSEL1,     1'b0);
    check({tag, ".psel2"},     PSEL2,     1'b0);
    check({tag, ".penable"},   PENABLE,   1'b0);
    check({tag, ".pwrite"},    PWRITE,    1'b0);
    check({tag, ".paddr"},     paddr,     8'h00);
    check({tag, ".pwdata"},    pwdata,    8'h00);
    check({tag, ".rsp_valid"}, rsp_valid, 1'b0);
    check({tag, ".rsp_id"},    rsp_id,    1'b0);
    check({tag, ".rsp_rdata"}, rsp_rdata, 8'h00);
    check({tag, ".rsp_err"},   rsp_err,   1'b0);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1; req_valid = 2'b00; PREADY1 = 1'b0; PREADY2 = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Each row is one clock cycle: inputs, then outputs expected in that cycle.
    //             rv     rw     a0     a1     d0     d1    r1 r2  pd1    pd2  | rdy   s1 s2 en wr addr   wd    rv rid rd
    // req0 write 0x05/0xA5, zero wait states.
    vecs.push_back('{2'b01, 2'b01, 8'h05, 8'h00, 8'hA5, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b01, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b00, 1, 0, 0, 1, 8'h05, 8'hA5, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b00, 1, 0, 1, 1, 8'h05, 8'hA5, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b00, 0, 0, 0, 1, 8'h05, 8'hA5, 1, 0, 8'h00});
    // req1 read 0x85, PREADY2 low for three ACCESS cycles; PREADY1 high must be ignored.
    vecs.push_back('{2'b10, 2'b00, 8'h00, 8'h85, 8'h00, 8'h11, 1, 0, 8'h99, 8'hEE, 2'b10, 0, 0, 0, 1, 8'h05, 8'hA5, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b00, 0, 1, 0, 0, 8'h85, 8'h11, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b00, 0, 1, 1, 0, 8'h85, 8'h11, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b00, 0, 1, 1, 0, 8'h85, 8'h11, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b00, 0, 1, 1, 0, 8'h85, 8'h11, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h99, 8'h3C, 2'b00, 0, 1, 1, 0, 8'h85, 8'h11, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h99, 8'hEE, 2'b00, 0, 0, 0, 0, 8'h85, 8'h11, 1, 1, 8'h3C});
    // Decode boundary: read 0x7F -> PSEL1, then back-to-back write 0x80 -> PSEL2.
    vecs.push_back('{2'b01, 2'b00, 8'h7F, 8'h00, 8'h00, 8'h00, 1, 1, 8'h5A, 8'hC3, 2'b01, 0, 0, 0, 0, 8'h85, 8'h11, 0, 1, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h5A, 8'hC3, 2'b00, 1, 0, 0, 0, 8'h7F, 8'h00, 0, 1, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h5A, 8'hC3, 2'b00, 1, 0, 1, 0, 8'h7F, 8'h00, 0, 1, 8'h00});
    vecs.push_back('{2'b01, 2'b01, 8'h80, 8'h00, 8'h42, 8'h00, 1, 1, 8'h5A, 8'hC3, 2'b01, 0, 0, 0, 0, 8'h7F, 8'h00, 1, 0, 8'h5A});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h5A, 8'hC3, 2'b00, 0, 1, 0, 1, 8'h80, 8'h42, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h5A, 8'hC3, 2'b00, 0, 1, 1, 1, 8'h80, 8'h42, 0, 0, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h5A, 8'hC3, 2'b00, 0, 0, 0, 1, 8'h80, 8'h42, 1, 0, 8'h00});

    // Reset state, with both requests already valid: nothing may be accepted.
    PRESET = 1'b1; req_valid = 2'b11; req_write = 2'b11;
    req_addr0 = 8'h12; req_addr1 = 8'h92; req_wdata0 = 8'h34; req_wdata1 = 8'h56;
    PREADY1 = 1'b1; PREADY2 = 1'b1; prdata1 = 8'h00; prdata2 = 8'h00;
    #1 check_all_zero("reset.t0");
    @(negedge PCLK); #1 check_all_zero("reset.clk");
    do_reset();

    foreach (vecs[i]) begin
      @(negedge PCLK);
      drive(vecs[i]);
      #1 check_vec(i, vecs[i]);
    end

    // Round-robin with both requesters valid continuously after reset.
    do_reset();
    req_addr0 = 8'h10; req_addr1 = 8'h90; req_write = 2'b11;
    req_wdata0 = 8'h01; req_wdata1 = 8'h02; PREADY1 = 1'b1; PREADY2 = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge PCLK);
      req_valid = 2'b11;
      #1;
      if (c % 3 == 0)
        check($sformatf("rr.c%0d.req_ready", c), req_ready, ((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
      else
        check($sformatf("rr.c%0d.req_ready", c), req_ready, 2'b00);
      check($sformatf("rr.c%0d.rsp_valid", c), rsp_valid, (c >= 3 && c % 3 == 0));
      if (c >= 3 && c % 3 == 0)
        check($sformatf("rr.c%0d.rsp_id", c), rsp_id, ((c / 3 - 1) % 2));
      check($sformatf("rr.c%0d.psel_both", c), PSEL1 & PSEL2, 1'b0);
    end

    // The last grant above went to req0 at 0x10; stall it and reset in ACCESS.
    @(negedge PCLK); req_valid = 2'b00; PREADY1 = 1'b0;
    #1 check("rst.setup.psel1", PSEL1, 1'b1);
    @(negedge PCLK); #1 check("rst.access.penable", PENABLE, 1'b1);
    @(negedge PCLK); #1;
    PRESET = 1'b1;
    #1;
    check("rst.async.psel1",   PSEL1,     1'b0);
    check("rst.async.psel2",   PSEL2,     1'b0);
    check("rst.async.penable", PENABLE,   1'b0);
    check("rst.async.pwrite",  PWRITE,    1'b0);
    check("rst.async.paddr",   paddr,     8'h00);
    check("rst.async.pwdata",  pwdata,    8'h00);
    check("rst.async.rsp",     rsp_valid, 1'b0);
    PREADY1 = 1'b1; req_valid = 2'b11;
    @(negedge PCLK); #1;
    check("rst.held.req_ready", req_ready, 2'b00);
    check("rst.held.rsp_valid", rsp_valid, 1'b0);
    @(negedge PCLK); PRESET = 1'b0; #1;
    check("rst.tie.req_ready", req_ready, 2'b01);
    check("rst.tie.rsp_valid", rsp_valid, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge PCLK); req_valid = 2'b00; #1;
      check($sformatf("rst.after.c%0d.rsp_valid", c), rsp_valid, (c == 3));
    end
    check("rst.after.rsp_id", rsp_id, 1'b0);

    // ACCESS stall: PREADY1 stuck low on a read from 0x30.
    @(negedge PCLK);
    req_valid = 2'b01; req_write = 2'b00; req_addr0 = 8'h30; PREADY1 = 1'b0; prdata1 = 8'h77;
    #1 check("to.accept", req_ready, 2'b01);
    @(negedge PCLK); req_valid = 2'b00;
    #1 check("to.setup.psel1", PSEL1, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge PCLK); #1;
      check($sformatf("to.acc%0d.penable", k), PENABLE, 1'b1);
      check($sformatf("to.acc%0d.rsp_valid", k), rsp_valid, 1'b0);
    end
    @(negedge PCLK); #1;
`ifdef APB_TIMEOUT_EN
    check("to.rsp_valid", rsp_valid, 1'b1);
    check("to.rsp_err",   rsp_err,   1'b1);
    check("to.rsp_rdata", rsp_rdata, 8'h00);
    check("to.rsp_id",    rsp_id,    1'b0);
    check("to.psel1",     PSEL1,     1'b0);
    check("to.penable",   PENABLE,   1'b0);
`else
    for (int k = 17; k <= 20; k++) begin
      check($sformatf("to.acc%0d.penable", k), PENABLE, 1'b1);
      check($sformatf("to.acc%0d.psel1", k), PSEL1, 1'b1);
      check($sformatf("to.acc%0d.rsp_valid", k), rsp_valid, 1'b0);
      check($sformatf("to.acc%0d.rsp_err", k), rsp_err, 1'b0);
      @(negedge PCLK); #1;
    end
    do_reset();
    #1 check("to.reset.penable", PENABLE, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
